// File: rtl/muldiv_sequencer_pkg.sv
// Shared ISA constants and enums for the iterative multiply/divide sequencer.
package muldiv_sequencer_pkg;

    localparam logic [3:0] ALU_SELECT_ARITHMETIC = 4'd1;
    localparam logic [6:0] FUNCT7_MULTIPLY       = 7'b0000001;

    localparam logic [2:0] FUNCT3_MUL   = 3'b000;
    localparam logic [2:0] FUNCT3_MULH  = 3'b001;
    localparam logic [2:0] FUNCT3_MULSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV   = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU  = 3'b101;
    localparam logic [2:0] FUNCT3_REM   = 3'b110;
    localparam logic [2:0] FUNCT3_REMU  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } muldiv_state_t;

    typedef enum logic [2:0] {
        OP_MUL   = 3'b000,
        OP_MULH  = 3'b001,
        OP_MULSU = 3'b010,
        OP_MULU  = 3'b011,
        OP_DIV   = 3'b100,
        OP_DIVU  = 3'b101,
        OP_REM   = 3'b110,
        OP_REMU  = 3'b111
    } muldiv_op_t;

    function automatic logic is_rem_op(muldiv_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared {hi,lo} accumulator: shift-add multiply step or
// restoring-divide step. Divide step exists only when MULDIV_DIV_EN is defined.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out
);

    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN:0]   mul_sum;
    logic [2*XLEN-1:0] mul_next;

    assign hi = acc_in[2*XLEN-1:XLEN];
    assign lo = acc_in[XLEN-1:0];

    // Multiplier lives in lo; the carry of the add shifts back into hi.
    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, lo[XLEN-1:1]};

`ifdef MULDIV_DIV_EN
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Remainder in hi, dividend shifting out of lo while quotient bits shift in.
    assign shifted = {hi, lo[XLEN-1]};
    assign diff    = shifted - {1'b0, operand};

    always_comb begin
        acc_out = mul_next;
        if (is_div) begin
            if (!diff[XLEN]) begin
                acc_out = {diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
            end else begin
                acc_out = {shifted[XLEN-1:0], lo[XLEN-2:0], 1'b0};
            end
        end
    end
`else
    assign acc_out = is_div ? acc_in : mul_next;
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV-style MUL/DIV sequencer with valid/ready handshake.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise divides return 0.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_select,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    muldiv_state_t     state;
    muldiv_op_t        op;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] step_acc;
    logic [XLEN-1:0]   operand_q;
    logic              negate;
    logic [CNT_W-1:0]  count;

    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              accept_req;
    logic              step_is_div;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   mul_result;

    assign in_ready    = (state == S_IDLE) && !flush && !reset;
    assign busy        = (state != S_IDLE);
    assign accept_req  = in_valid && in_ready &&
                         (alu_select == ALU_SELECT_ARITHMETIC) &&
                         (funct7 == FUNCT7_MULTIPLY);

    assign a_neg = operand_a[XLEN-1];
    assign b_neg = operand_b[XLEN-1];
    assign abs_a = a_neg ? -operand_a : operand_a;
    assign abs_b = b_neg ? -operand_b : operand_b;

    assign step_is_div = (state == S_DIV);

    muldiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .is_div  (step_is_div),
        .acc_in  (acc),
        .operand (operand_q),
        .acc_out (step_acc)
    );

    // Signed variants iterated on magnitudes; the sign is restored here.
    assign product    = negate ? -acc : acc;
    assign mul_result = (op == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];

`ifdef MULDIV_DIV_EN
    logic [XLEN-1:0] orig_a;
    logic            special;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    logic [XLEN-1:0] div_result;
    logic [XLEN-1:0] special_result;

    assign quotient   = acc[XLEN-1:0];
    assign remainder  = acc[2*XLEN-1:XLEN];
    assign div_result = is_rem_op(op) ? (negate ? -remainder : remainder)
                                      : (negate ? -quotient  : quotient);

    // operand_q holds |b|, so zero here means divide-by-zero, else signed overflow.
    assign special_result = (operand_q == '0) ? (is_rem_op(op) ? orig_a : {XLEN{1'b1}})
                                              : (is_rem_op(op) ? {XLEN{1'b0}} : orig_a);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            op        <= OP_MUL;
            acc       <= '0;
            operand_q <= '0;
            negate    <= 1'b0;
            count     <= '0;
            result    <= '0;
            out_valid <= 1'b0;
`ifdef MULDIV_DIV_EN
            orig_a    <= '0;
            special   <= 1'b0;
`endif
        end else if (flush) begin
            state     <= S_IDLE;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_req) begin
                        op    <= muldiv_op_t'(funct3);
                        count <= '0;
                        // Unknown funct3 falls to default and is not accepted.
                        case (funct3)
                            FUNCT3_MUL, FUNCT3_MULU: begin
                                acc       <= {{XLEN{1'b0}}, operand_a};
                                operand_q <= operand_b;
                                negate    <= 1'b0;
                                state     <= S_MUL;
                            end
                            FUNCT3_MULH: begin
                                acc       <= {{XLEN{1'b0}}, abs_a};
                                operand_q <= abs_b;
                                negate    <= a_neg ^ b_neg;
                                state     <= S_MUL;
                            end
                            FUNCT3_MULSU: begin
                                acc       <= {{XLEN{1'b0}}, abs_a};
                                operand_q <= operand_b;
                                negate    <= a_neg;
                                state     <= S_MUL;
                            end
                            FUNCT3_DIV, FUNCT3_REM: begin
`ifdef MULDIV_DIV_EN
                                acc       <= {{XLEN{1'b0}}, abs_a};
                                operand_q <= abs_b;
                                negate    <= (funct3 == FUNCT3_DIV) ? (a_neg ^ b_neg) : a_neg;
                                orig_a    <= operand_a;
                                special   <= (operand_b == '0) ||
                                             ((operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                                              (operand_b == {XLEN{1'b1}}));
                                state     <= S_DIV;
`else
                                result    <= '0;
                                out_valid <= 1'b1;
                                state     <= S_DONE;
`endif
                            end
                            FUNCT3_DIVU, FUNCT3_REMU: begin
`ifdef MULDIV_DIV_EN
                                acc       <= {{XLEN{1'b0}}, operand_a};
                                operand_q <= operand_b;
                                negate    <= 1'b0;
                                orig_a    <= operand_a;
                                special   <= (operand_b == '0);
                                state     <= S_DIV;
`else
                                result    <= '0;
                                out_valid <= 1'b1;
                                state     <= S_DONE;
`endif
                            end
                            default: begin
                                state <= S_IDLE;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    if (count == CNT_W'(XLEN)) begin
                        result    <= mul_result;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        acc   <= step_acc;
                        count <= count + CNT_W'(1);
                    end
                end
                S_DIV: begin
`ifdef MULDIV_DIV_EN
                    if (special) begin
                        result    <= special_result;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else if (count == CNT_W'(XLEN)) begin
                        result    <= div_result;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        acc   <= step_acc;
                        count <= count + CNT_W'(1);
                    end
`else
                    state <= S_IDLE;
`endif
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer at XLEN=32; expectations follow MULDIV_DIV_EN.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_select = 4'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] operand_a = 32'd0;
    logic [31:0] operand_b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    muldiv_sequencer #(
        .XLEN(32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_select (alu_select),
        .funct3     (funct3),
        .funct7     (funct7),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic        [63:0] up;
        logic signed [31:0] da, db;
        sa = {{32{a[31]}}, a};
        da = a;
        db = b;
        case (f3)
            FUNCT3_MUL:   begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            FUNCT3_MULH:  begin sb = {{32{b[31]}}, b}; sp = sa * sb; return sp[63:32]; end
            FUNCT3_MULSU: begin sb = {32'd0, b}; sp = sa * sb; return sp[63:32]; end
            FUNCT3_MULU:  begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
`ifdef MULDIV_DIV_EN
            FUNCT3_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(da / db);
            end
            FUNCT3_REM: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(da % db);
            end
            FUNCT3_DIVU: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default:     return (b == 32'd0) ? a : a % b;
`else
            default:     return 32'd0;
`endif
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 33;
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) return 1;
        if ((f3 == FUNCT3_DIV || f3 == FUNCT3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
`else
        return (a == a) ? 0 : 0;
`endif
    endfunction

    task automatic drive_request(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid   = 1'b1;
        alu_select = ALU_SELECT_ARITHMETIC;
        funct7     = FUNCT7_MULTIPLY;
        funct3     = f3;
        operand_a  = a;
        operand_b  = b;
        check_output("in_ready_idle", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_output("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    task automatic wait_result(input string tag);
        int   cycles;
        exp_t e;
        cycles = 0;
        while (!out_valid && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!out_valid) begin
            check_output({tag, "_timeout"}, 64'd0, 64'd1);
        end else if (sb_q.size() == 0) begin
            check_output({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check_output({tag, "_result"}, {32'd0, result}, {32'd0, e.res});
            check_output({tag, "_latency"}, 64'(cycles), 64'(e.lat));
        end
    endtask

    task automatic release_result(input logic [31:0] held, input int hold);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check_output("hold_result", {32'd0, result}, {32'd0, held});
            check_output("hold_valid", {63'd0, out_valid}, 64'd1);
            check_output("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_output("release_valid", {63'd0, out_valid}, 64'd0);
        check_output("release_in_ready", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  input int hold, input string tag);
        exp_t e;
        e.res = ref_model(f3, a, b);
        e.lat = exp_latency(f3, a, b);
        sb_q.push_back(e);
        drive_request(f3, a, b);
        wait_result(tag);
        release_result(e.res, hold);
    endtask

    initial begin
        int seen;
        exp_t e;

        $display("[TB] start");
        #12;
        check_output("reset_in_ready", {63'd0, in_ready}, 64'd0);
        check_output("reset_busy", {63'd0, busy}, 64'd0);
        check_output("reset_valid", {63'd0, out_valid}, 64'd0);
        check_output("reset_result", {32'd0, result}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Requests outside the multiply class must be ignored.
        @(negedge clk);
        in_valid   = 1'b1;
        alu_select = 4'd0;
        funct7     = FUNCT7_MULTIPLY;
        @(posedge clk);
        #1;
        check_output("ignore_alu_select", {63'd0, busy}, 64'd0);
        @(negedge clk);
        alu_select = ALU_SELECT_ARITHMETIC;
        funct7     = 7'b0100000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_output("ignore_funct7", {63'd0, busy}, 64'd0);

        apply_stimulus(FUNCT3_MULU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,  "mulu_max");
        apply_stimulus(FUNCT3_MULH,  32'h8000_0000, 32'h8000_0000, 0,  "mulh_min");
        apply_stimulus(FUNCT3_MULSU, 32'hFFFF_FFFF, 32'd2,         0,  "mulsu_neg");
        apply_stimulus(FUNCT3_MUL,   32'd6,         32'd7,         10, "mul_backpressure");
        apply_stimulus(FUNCT3_DIV,   32'hFFFF_FFF9, 32'd2,         0,  "div_neg");
        apply_stimulus(FUNCT3_REM,   32'hFFFF_FFF9, 32'd2,         0,  "rem_neg");
        apply_stimulus(FUNCT3_DIVU,  32'd7,         32'd0,         0,  "divu_zero");
        apply_stimulus(FUNCT3_REMU,  32'd7,         32'd0,         0,  "remu_zero");
        apply_stimulus(FUNCT3_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0,  "div_ovf");
        apply_stimulus(FUNCT3_REM,   32'h8000_0000, 32'hFFFF_FFFF, 0,  "rem_ovf");
        apply_stimulus(FUNCT3_DIV,   32'd10,        32'd2,         0,  "div_10_2");
        apply_stimulus(FUNCT3_DIVU,  32'hFFFF_FFFF, 32'd3,         0,  "divu_big");

        for (int i = 0; i < 10; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            apply_stimulus(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 2), "random");
        end

        // A new request while DONE is handing off must wait for IDLE.
        e.res = ref_model(FUNCT3_MUL, 32'd3, 32'd5);
        e.lat = 33;
        sb_q.push_back(e);
        drive_request(FUNCT3_MUL, 32'd3, 32'd5);
        wait_result("mul_3_5");
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        funct3    = FUNCT3_MUL;
        operand_a = 32'd4;
        operand_b = 32'd5;
        check_output("done_in_ready", {63'd0, in_ready}, 64'd0);
        e.res = 32'd20;
        e.lat = 33;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_output("done_no_accept", {63'd0, busy}, 64'd0);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_output("idle_accept", {63'd0, busy}, 64'd1);
        wait_result("mul_4_5");
        release_result(32'd20, 0);

        // Flush mid-operation, with a competing request, drops everything.
`ifdef MULDIV_DIV_EN
        drive_request(FUNCT3_DIV, 32'd1000, 32'd3);
`else
        drive_request(FUNCT3_MUL, 32'd1000, 32'd3);
`endif
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        check_output("flush_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        check_output("flush_busy", {63'd0, busy}, 64'd0);
        check_output("flush_valid", {63'd0, out_valid}, 64'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen++;
        end
        check_output("flush_no_result", 64'(seen), 64'd0);

        // Asynchronous reset in the middle of a multiply.
        drive_request(FUNCT3_MUL, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_output("async_reset_busy", {63'd0, busy}, 64'd0);
        check_output("async_reset_valid", {63'd0, out_valid}, 64'd0);
        check_output("async_reset_result", {32'd0, result}, 64'd0);
        check_output("async_reset_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("after_reset_in_ready", {63'd0, in_ready}, 64'd1);

        apply_stimulus(FUNCT3_MUL, 32'd6, 32'd7, 0, "mul_after_reset");
        check_output("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
